axi4lite_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command interface into AXI4-Lite read or write transactions.
- Returns the data and response on a valid/ready response interface.
- Sits between the test/host logic or a CPU-side bridge and the AXI4-Lite register-block slave, as its traffic source.
- Includes a programmable response-timeout watchdog with a sticky error flag.

---
 rtl/axi4lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// axi4lite_master: single-outstanding AXI4-Lite initiator.
// Converts one cmd_valid/cmd_ready command into an AXI4-Lite read or write. The result comes back
// on a rsp_valid/rsp_ready interface. A response watchdog raises a sticky timeout_err flag when a
// transaction takes too long, but it never abandons the bus transaction.
// Ports:
//   M_AXI_clk, M_AXI_rst        clock, asynchronous active-high reset
//   cmd_*                       command in (is_wr, addr, wdata, wstrb)
//   rsp_*                       response out (is_wr, rdata, resp)
//   timeout_clr / timeout_err   watchdog clear / sticky flag
//   M_AXI_*                     AXI4-Lite master channels AW, W, B, AR, R
module axi4lite_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [3:0]  C_AXI_CACHE        = 4'b0011,
    parameter logic [2:0]  C_AXI_PROT         = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_clk,
    input  logic                              M_AXI_rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_is_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_is_wr,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    input  logic                              timeout_clr,
    output logic                              timeout_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    // Watchdog counter is just wide enough to hold TIMEOUT_CYCLES; it saturates there.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    state_e                              state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]       addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]       wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]     wstrb_q;
    logic                                aw_done_q;
    logic                                w_done_q;
    logic [CntW-1:0]                     wd_cnt_q;

    logic aw_hs;
    logic w_hs;
    logic busy;

    assign cmd_ready = (state_q == StIdle);
    assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign busy      = (state_q == StWrReq) || (state_q == StWrResp) ||
                       (state_q == StRdReq) || (state_q == StRdResp);

    // Address and data come straight from the command latch, so they cannot move while VALID is up.
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWCACHE = C_AXI_CACHE;
    assign M_AXI_ARCACHE = C_AXI_CACHE;
    assign M_AXI_AWPROT  = C_AXI_PROT;
    assign M_AXI_ARPROT  = C_AXI_PROT;

    always_ff @(posedge M_AXI_clk or posedge M_AXI_rst) begin
        if (M_AXI_rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            wd_cnt_q      <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_is_wr     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            timeout_err   <= 1'b0;
        end else begin
            if (timeout_clr) begin
                timeout_err <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wd_cnt_q  <= '0;
                        if (cmd_is_wr) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state_q       <= StWrReq;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state_q       <= StRdReq;
                        end
                    end
                end
                StWrReq: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done_q     <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done_q     <= 1'b1;
                    end
                    // Either channel may finish on this edge or an earlier one.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state_q      <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID && M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_is_wr    <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state_q      <= StRsp;
                    end
                end
                StRdReq: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state_q       <= StRdResp;
                    end
                end
                StRdResp: begin
                    if (M_AXI_RVALID && M_AXI_RREADY) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_is_wr    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state_q      <= StRsp;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Watchdog: placed after the clear so a coincident expiry wins.
            if ((TIMEOUT_CYCLES != 0) && busy) begin
                if (wd_cnt_q != CntLimit) begin
                    wd_cnt_q <= wd_cnt_q + CntW'(1);
                end
                if (wd_cnt_q + CntW'(1) == CntLimit) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_master.sv
// Testbench for axi4lite_master: directed and randomized transactions against a behavioural slave
// with per-channel ready/valid delays, checked against a response queue and latency arithmetic.
module tb_axi4lite_master;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_is_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_is_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_clr = 1'b0, timeout_err;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [3:0]  awcache, arcache, wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    axi4lite_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_AXI_CACHE        (4'b0011),
        .C_AXI_PROT         (3'b000),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .M_AXI_clk     (clk),
        .M_AXI_rst     (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_is_wr     (cmd_is_wr),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_is_wr     (rsp_is_wr),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .timeout_clr   (timeout_clr),
        .timeout_err   (timeout_err),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWCACHE (awcache),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: expected responses in issue order, plus the sticky watchdog flag.
    typedef struct {
        logic        is_wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;
    rsp_t exp_q[$];
    logic tmo_model = 1'b0;

    // Slave configuration set by the stimulus before each command.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  resp_cfg = '0;
    logic [31:0] rdata_cfg = '0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;

    // Behavioural slave, updated on negedge. *_hs flags record handshakes due at the next posedge.
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    bit aw_got, w_got, ar_got, b_pend, r_pend, aw_hs, w_hs, ar_hs, b_hs, r_hs;

    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
            aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        end else begin
            if (aw_hs) begin awready = 0; aw_got = 1; aw_cnt = 0; end
            if (w_hs)  begin wready = 0;  w_got = 1;  w_cnt = 0;  end
            if (ar_hs) begin arready = 0; ar_got = 1; ar_cnt = 0; end
            if (b_hs) bvalid = 0;
            if (r_hs) rvalid = 0;
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = b_dly; end
            if (ar_got) begin ar_got = 0; r_pend = 1; r_wait = r_dly; end
            if (b_pend) begin
                if (b_wait == 0) begin bvalid = 1; bresp = resp_cfg; b_pend = 0; end
                else b_wait--;
            end
            if (r_pend) begin
                if (r_wait == 0) begin
                    rvalid = 1; rresp = resp_cfg; rdata = rdata_cfg; r_pend = 0;
                end else r_wait--;
            end
            if (awvalid) begin
                check("awaddr", 64'(awaddr), 64'(cur_addr));
                check("awcache_awprot", 64'({awcache, awprot}), 64'(7'b0011_000));
                if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
            end
            if (wvalid) begin
                check("wdata_wstrb", {28'd0, wstrb, wdata}, {28'd0, cur_wstrb, cur_wdata});
                if (w_cnt >= w_dly) wready = 1; else w_cnt++;
            end
            if (arvalid) begin
                check("araddr", 64'(araddr), 64'(cur_addr));
                check("arcache_arprot", 64'({arcache, arprot}), 64'(7'b0011_000));
                if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            b_hs  = bvalid && bready;
            r_hs  = rvalid && rready;
        end
    end

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd_v,
                           input logic [3:0] strb, input int awd, input int wdd, input int bd,
                           input int ard, input int rd, input logic [1:0] resp,
                           input logic [31:0] rd_v, input int hold, input bit wd_probe);
        int   e;
        int   m;
        int   lat_exp;
        rsp_t ex;
        aw_dly = awd; w_dly = wdd; b_dly = bd; ar_dly = ard; r_dly = rd;
        resp_cfg = resp; rdata_cfg = rd_v;
        cur_addr = addr; cur_wdata = wd_v; cur_wstrb = strb;
        cmd_is_wr = wr; cmd_addr = addr; cmd_wdata = wd_v; cmd_wstrb = strb; cmd_valid = 1;
        e = 0;
        while (!cmd_ready && e < 50) begin @(negedge clk); e++; end
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        m = (awd > wdd) ? awd : wdd;
        // First posedge at which rsp_valid is sampled high, counted from the command edge.
        lat_exp = wr ? 3 + m + bd : 3 + ard + rd;
        ex.is_wr = wr; ex.rdata = wr ? 32'd0 : rd_v; ex.resp = resp;
        exp_q.push_back(ex);
        if (lat_exp - 1 >= int'(TMO)) tmo_model = 1'b1;
        e = 0;
        while (1) begin
            if (wr) begin
                check("awvalid", 64'(awvalid), 64'(e < 1 + awd));
                check("wvalid", 64'(wvalid), 64'(e < 1 + wdd));
                check("bready", 64'(bready), 64'(e >= 1 + m && e < 2 + m + bd));
                check("arvalid_wr", 64'(arvalid), 64'(0));
            end else begin
                check("arvalid", 64'(arvalid), 64'(e < 1 + ard));
                check("rready", 64'(rready), 64'(e >= 1 + ard && e < 2 + ard + rd));
                check("awvalid_rd", 64'({awvalid, wvalid}), 64'(0));
            end
            if (wd_probe && e == 4) check("tmo_early", 64'(timeout_err), 64'(0));
            if (wd_probe && e == 12) begin
                check("tmo_set", 64'(timeout_err), 64'(1));
                check("tmo_bready_held", 64'(bready), 64'(1));
            end
            if (rsp_valid || e >= 200) break;
            @(negedge clk);
            e++;
        end
        check("latency", 64'(e + 1), 64'(lat_exp));
        ex = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 64'(rsp_valid), 64'(1));
            check("rsp_is_wr", 64'(rsp_is_wr), 64'(ex.is_wr));
            check("rsp_rdata", 64'(rsp_rdata), 64'(ex.rdata));
            check("rsp_resp", 64'(rsp_resp), 64'(ex.resp));
            check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            check("timeout_err", 64'(timeout_err), 64'(tmo_model));
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'(0));
        check("rst_rsp", 64'({rsp_is_wr, rsp_resp, rsp_rdata}), 64'(0));
        check("rst_tmo_addr", 64'({timeout_err, awaddr}), 64'(0));
        rst = 0;
        @(negedge clk);

        run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
        run_txn(1, 32'h0000_0020, 32'hCAFE_0001, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
        run_txn(1, 32'h0000_0024, 32'h0BAD_F00D, 4'hC, 0, 3, 1, 0, 0, 2'b11, 32'h0, 0, 0);
        run_txn(0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 0);
        run_txn(0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, 32'h8765_4321, 5, 0);

        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom % 2), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom % 16),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 2'($urandom % 4), $urandom,
                    int'($urandom_range(0, 2)), 0);
        end

        // Slave withholds BVALID well past the watchdog limit; transaction still completes.
        run_txn(1, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 0, 0, 20, 0, 0, 2'b00, 32'h0, 0, 1);
        check("tmo_sticky", 64'(timeout_err), 64'(1));
        timeout_clr = 1;
        @(negedge clk);
        timeout_clr = 0;
        tmo_model = 1'b0;
        check("tmo_clear", 64'(timeout_err), 64'(0));

        // Reset in the middle of a read data phase.
        ar_dly = 0; r_dly = 10; resp_cfg = 2'b00; rdata_cfg = 32'hFFFF_0000;
        cur_addr = 32'h0000_0080;
        cmd_is_wr = 0; cmd_addr = cur_addr; cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("pre_rst_rready", 64'(rready), 64'(1));
        #2 rst = 1;
        #1;
        check("rst_async_valids", 64'({arvalid, rready, rsp_valid}), 64'(0));
        check("rst_async_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 0;
        tmo_model = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
            check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        end

        run_txn(0, 32'h0000_00C0, 32'h0, 4'h0, 1, 0, 0, 0, 1, 2'b01, 32'hA5A5_5A5A, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
